loop_gain_scheduler: RTL and testbench

Gain-scheduling controller for the ADPLL loop filter running in dynamic-gain mode. It watches the signed phase error, starts acquisition with high kp/ki, and steps to lower-gain "gears" each time the error stays small for long enough. It asserts lock in the final gear and falls back to gear 0 on loss of lock. Its kp_o/ki_o outputs drive the loop filter's kp_i/ki_i directly.

---
 rtl/loop_gain_scheduler_pkg.sv | 30 +++
 rtl/loop_gain_scheduler_error_band_detect.sv | 33 +++
 rtl/loop_gain_scheduler.sv | 178 +++++++++++++++++
 tb/tb_loop_gain_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_gain_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Module   : loop_gain_scheduler_pkg
// Purpose  : Shared ADPLL definitions: scheduler state encoding and the
//            default loop-filter gain tables and fixed-point formats.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package loop_gain_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_LOCKED  = 2'd3
    } lgs_state_e;

    // kp is Q2.1, ki is Q1.3; shared with the loop filter
    localparam int c_kp_width     = 3;
    localparam int c_kp_frac_bits = 1;
    localparam int c_ki_width     = 4;
    localparam int c_ki_frac_bits = 3;

    // Gear g occupies bits [g*width +: width]; gear 0 is the highest gain
    localparam logic [11:0] c_default_kp_table = 12'b001_001_010_011;
    localparam logic [15:0] c_default_ki_table = 16'b0001_0010_0100_0111;

endpackage

`default_nettype wire

// File: rtl/loop_gain_scheduler_error_band_detect.sv
//------------------------------------------------------------------------------
// Module   : error_band_detect
// Purpose  : Classifies a signed phase error as in-band / out-of-lock using a
//            magnitude widened by one bit so the most negative code is large.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module error_band_detect #(
    parameter int ERROR_WIDTH   = 8,
    parameter int LOCK_THRESH   = 2,
    parameter int UNLOCK_THRESH = 16
) (
    input  logic [ERROR_WIDTH-1:0] i_error,
    output logic                   o_in_band,
    output logic                   o_out_of_lock
);

    localparam logic [ERROR_WIDTH:0] c_lock_thresh   = (ERROR_WIDTH+1)'(LOCK_THRESH);
    localparam logic [ERROR_WIDTH:0] c_unlock_thresh = (ERROR_WIDTH+1)'(UNLOCK_THRESH);

    logic [ERROR_WIDTH:0] w_err_ext;
    logic [ERROR_WIDTH:0] w_abs;

    assign w_err_ext     = {i_error[ERROR_WIDTH-1], i_error};
    assign w_abs         = w_err_ext[ERROR_WIDTH] ? ({(ERROR_WIDTH+1){1'b0}} - w_err_ext)
                                                  : w_err_ext;
    assign o_in_band     = (w_abs <= c_lock_thresh);
    assign o_out_of_lock = (w_abs > c_unlock_thresh);

endmodule

`default_nettype wire

// File: rtl/loop_gain_scheduler.sv
//------------------------------------------------------------------------------
// Module   : loop_gain_scheduler
// Purpose  : ADPLL dynamic-gain scheduler: steps kp/ki down through gain gears
//            as the phase error settles, flags lock, and falls back on loss.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module loop_gain_scheduler
    import loop_gain_scheduler_pkg::*;
#(
    parameter int                            ERROR_WIDTH    = 8,
    parameter int                            KP_WIDTH       = c_kp_width,
    parameter int                            KI_WIDTH       = c_ki_width,
    parameter int                            NUM_GEARS      = 4,
    parameter int                            GEAR_WIDTH     = 2,
    parameter logic [NUM_GEARS*KP_WIDTH-1:0] KP_TABLE       = c_default_kp_table,
    parameter logic [NUM_GEARS*KI_WIDTH-1:0] KI_TABLE       = c_default_ki_table,
    parameter int                            LOCK_THRESH    = 2,
    parameter int                            UNLOCK_THRESH  = 16,
    parameter int                            LOCK_COUNT     = 16,
    parameter int                            SETTLE_SAMPLES = 4,
    parameter int                            CNT_WIDTH      = 8
) (
    input  logic                   gen_clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   error_valid_i,
    input  logic [ERROR_WIDTH-1:0] error_i,
    input  logic                   force_i,
    input  logic [GEAR_WIDTH-1:0]  force_gear_i,
    output logic [KP_WIDTH-1:0]    kp_o,
    output logic [KI_WIDTH-1:0]    ki_o,
    output logic [GEAR_WIDTH-1:0]  gear_o,
    output logic                   locked_o,
    output logic                   gear_change_o
);

    localparam logic [GEAR_WIDTH-1:0] c_last_gear   = GEAR_WIDTH'(NUM_GEARS-1);
    localparam logic [CNT_WIDTH-1:0]  c_run_last    = CNT_WIDTH'(LOCK_COUNT-1);
    localparam logic [CNT_WIDTH-1:0]  c_settle_last = CNT_WIDTH'(SETTLE_SAMPLES-1);

    lgs_state_e            r_state;
    logic [GEAR_WIDTH-1:0] r_gear;
    logic [KP_WIDTH-1:0]   r_kp;
    logic [KI_WIDTH-1:0]   r_ki;
    logic                  r_locked;
    logic                  r_gear_change;
    logic [CNT_WIDTH-1:0]  r_run_cnt;
    logic [CNT_WIDTH-1:0]  r_settle_cnt;

    logic                  w_in_band;
    logic                  w_out_of_lock;
    logic [GEAR_WIDTH-1:0] w_force_gear;
    logic [GEAR_WIDTH-1:0] w_gear_inc;

    function automatic logic [KP_WIDTH-1:0] kp_of(input logic [GEAR_WIDTH-1:0] g);
        return KP_TABLE[g*KP_WIDTH +: KP_WIDTH];
    endfunction

    function automatic logic [KI_WIDTH-1:0] ki_of(input logic [GEAR_WIDTH-1:0] g);
        return KI_TABLE[g*KI_WIDTH +: KI_WIDTH];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == {CNT_WIDTH{1'b1}}) ? c : c + 1'b1;
    endfunction

    error_band_detect #(
        .ERROR_WIDTH   (ERROR_WIDTH),
        .LOCK_THRESH   (LOCK_THRESH),
        .UNLOCK_THRESH (UNLOCK_THRESH)
    ) u_band (
        .i_error       (error_i),
        .o_in_band     (w_in_band),
        .o_out_of_lock (w_out_of_lock)
    );

    assign w_force_gear = (force_gear_i > c_last_gear) ? c_last_gear : force_gear_i;
    assign w_gear_inc   = r_gear + 1'b1;

    // kp/ki are reloaded on every edge that moves the gear so they never lag it
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= ST_IDLE;
            r_gear        <= '0;
            r_kp          <= kp_of('0);
            r_ki          <= ki_of('0);
            r_locked      <= 1'b0;
            r_gear_change <= 1'b0;
            r_run_cnt     <= '0;
            r_settle_cnt  <= '0;
        end else begin
            r_gear_change <= 1'b0;
            if (!enable_i) begin
                r_state       <= ST_IDLE;
                r_gear        <= '0;
                r_kp          <= kp_of('0);
                r_ki          <= ki_of('0);
                r_locked      <= 1'b0;
                r_run_cnt     <= '0;
                r_settle_cnt  <= '0;
                r_gear_change <= (r_gear != '0);
            end else if (force_i) begin
                r_state       <= ST_ACQUIRE;
                r_gear        <= w_force_gear;
                r_kp          <= kp_of(w_force_gear);
                r_ki          <= ki_of(w_force_gear);
                r_locked      <= 1'b0;
                r_run_cnt     <= '0;
                r_settle_cnt  <= '0;
                r_gear_change <= (w_force_gear != r_gear);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_ACQUIRE;
                        r_run_cnt <= '0;
                    end
                    ST_ACQUIRE: begin
                        if (error_valid_i) begin
                            if (!w_in_band) begin
                                r_run_cnt <= '0;
                            end else if (r_run_cnt >= c_run_last) begin
                                r_run_cnt <= '0;
                                if (r_gear != c_last_gear) begin
                                    r_gear        <= w_gear_inc;
                                    r_kp          <= kp_of(w_gear_inc);
                                    r_ki          <= ki_of(w_gear_inc);
                                    r_gear_change <= 1'b1;
                                    r_settle_cnt  <= '0;
                                    r_state       <= ST_SETTLE;
                                end else begin
                                    r_locked <= 1'b1;
                                    r_state  <= ST_LOCKED;
                                end
                            end else begin
                                r_run_cnt <= sat_inc(r_run_cnt);
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (error_valid_i) begin
                            if (r_settle_cnt >= c_settle_last) begin
                                r_state      <= ST_ACQUIRE;
                                r_settle_cnt <= '0;
                                r_run_cnt    <= '0;
                            end else begin
                                r_settle_cnt <= sat_inc(r_settle_cnt);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (error_valid_i && w_out_of_lock) begin
                            r_locked      <= 1'b0;
                            r_gear        <= '0;
                            r_kp          <= kp_of('0);
                            r_ki          <= ki_of('0);
                            r_gear_change <= (r_gear != '0);
                            r_settle_cnt  <= '0;
                            r_run_cnt     <= '0;
                            r_state       <= ST_SETTLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign kp_o          = r_kp;
    assign ki_o          = r_ki;
    assign gear_o        = r_gear;
    assign locked_o      = r_locked;
    assign gear_change_o = r_gear_change;

endmodule

`default_nettype wire

// File: tb/tb_loop_gain_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_loop_gain_scheduler
// Purpose  : Self-checking bench for loop_gain_scheduler: table-driven phases,
//            hand-written corner sequences and randomized model comparison.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_loop_gain_scheduler;

    logic       gen_clk_i = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic       error_valid_i;
    logic [7:0] error_i;
    logic       force_i;
    logic [1:0] force_gear_i;
    logic [2:0] kp_o;
    logic [3:0] ki_o;
    logic [1:0] gear_o;
    logic       locked_o;
    logic       gear_change_o;

    int total = 0;
    int bad   = 0;
    int pulses;

    loop_gain_scheduler dut (
        .gen_clk_i     (gen_clk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .error_valid_i (error_valid_i),
        .error_i       (error_i),
        .force_i       (force_i),
        .force_gear_i  (force_gear_i),
        .kp_o          (kp_o),
        .ki_o          (ki_o),
        .gear_o        (gear_o),
        .locked_o      (locked_o),
        .gear_change_o (gear_change_o)
    );

    always #5 gen_clk_i = ~gen_clk_i;

    function automatic int exp_kp(input int g);
        case (g)
            0:       return 3;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int exp_ki(input int g);
        case (g)
            0:       return 7;
            1:       return 4;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    // Reference model: phase-based, counting remaining samples rather than runs
    localparam int M_IDLE = 0, M_ACQ = 1, M_SETTLE = 2, M_LOCKED = 3;
    int m_phase, m_run, m_settle_left, m_gear, m_locked, m_chg;
    int m_old, m_mag, m_err, m_fg;

    always @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            m_phase = M_IDLE; m_run = 0; m_settle_left = 0;
            m_gear = 0; m_locked = 0; m_chg = 0;
        end else begin
            m_old = m_gear;
            m_err = int'($signed(error_i));
            m_mag = (m_err < 0) ? -m_err : m_err;
            if (!enable_i) begin
                m_phase = M_IDLE; m_gear = 0; m_locked = 0; m_run = 0; m_settle_left = 0;
            end else if (force_i) begin
                m_fg = (int'(force_gear_i) > 3) ? 3 : int'(force_gear_i);
                m_phase = M_ACQ; m_gear = m_fg; m_locked = 0; m_run = 0;
            end else if (m_phase == M_IDLE) begin
                m_phase = M_ACQ; m_run = 0;
            end else if (error_valid_i) begin
                if (m_phase == M_ACQ) begin
                    m_run = (m_mag <= 2) ? m_run + 1 : 0;
                    if (m_run == 16) begin
                        m_run = 0;
                        if (m_gear < 3) begin
                            m_gear = m_gear + 1; m_phase = M_SETTLE; m_settle_left = 4;
                        end else begin
                            m_locked = 1; m_phase = M_LOCKED;
                        end
                    end
                end else if (m_phase == M_SETTLE) begin
                    m_settle_left = m_settle_left - 1;
                    if (m_settle_left == 0) begin
                        m_phase = M_ACQ; m_run = 0;
                    end
                end else if (m_mag > 16) begin
                    m_locked = 0; m_gear = 0; m_phase = M_SETTLE; m_settle_left = 4;
                end
            end
            m_chg = (m_gear != m_old) ? 1 : 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit en, input bit v, input int err, input bit f, input int fg);
        enable_i      = en;
        error_valid_i = v;
        error_i       = 8'(err);
        force_i       = f;
        force_gear_i  = 2'(fg);
        @(posedge gen_clk_i);
        @(negedge gen_clk_i);
        if (gear_change_o) pulses++;
    endtask

    task automatic ticks(input int n, input bit en, input bit v, input int err);
        for (int k = 0; k < n; k++) tick(en, v, err, 1'b0, 0);
    endtask

    typedef struct {
        bit en; bit v; int err; bit f; int fg; int n;
        int gear; int lock; int pulses;
    } row_t;

    function automatic row_t mk(input bit en, input bit v, input int err, input bit f,
                                input int fg, input int n, input int gear, input int lock,
                                input int p);
        row_t r;
        r.en = en; r.v = v; r.err = err; r.f = f; r.fg = fg; r.n = n;
        r.gear = gear; r.lock = lock; r.pulses = p;
        return r;
    endfunction

    row_t tbl[$];
    int   total_pulses;

    initial begin
        tbl.push_back(mk(1, 0,    0, 0, 0,   1, 0, 0, 0));  // idle -> acquire
        tbl.push_back(mk(1, 1,    0, 0, 0,  15, 0, 0, 0));
        tbl.push_back(mk(1, 1,    0, 0, 0,   1, 1, 0, 1));  // sample 16
        tbl.push_back(mk(1, 1,    0, 0, 0,  19, 1, 0, 0));
        tbl.push_back(mk(1, 1,    0, 0, 0,   1, 2, 0, 1));  // sample 36
        tbl.push_back(mk(1, 1,    0, 0, 0,  19, 2, 0, 0));
        tbl.push_back(mk(1, 1,    0, 0, 0,   1, 3, 0, 1));  // sample 56
        tbl.push_back(mk(1, 1,    0, 0, 0,  19, 3, 0, 0));
        tbl.push_back(mk(1, 1,    0, 0, 0,   1, 3, 1, 0));  // sample 76 locks
        tbl.push_back(mk(1, 0,    0, 0, 0, 100, 3, 1, 0));
        tbl.push_back(mk(0, 0,    0, 0, 0,   1, 0, 0, 1));  // enable low
        tbl.push_back(mk(1, 0,    0, 1, 2,   1, 2, 0, 1));  // force gear 2
        tbl.push_back(mk(1, 1,    0, 1, 2,   3, 2, 0, 0));  // force held
        tbl.push_back(mk(1, 1,    0, 0, 0,  15, 2, 0, 0));
        tbl.push_back(mk(1, 1,    0, 0, 0,   1, 3, 0, 1));
        tbl.push_back(mk(1, 1,  100, 0, 0,   4, 3, 0, 0));  // settle ignores error
        tbl.push_back(mk(1, 1,    0, 0, 0,  15, 3, 0, 0));
        tbl.push_back(mk(1, 1,    0, 0, 0,   1, 3, 1, 0));
        tbl.push_back(mk(0, 0,    0, 0, 0,   1, 0, 0, 1));
        tbl.push_back(mk(1, 0,    0, 0, 0,   1, 0, 0, 0));
        tbl.push_back(mk(1, 1,    0, 0, 0,  15, 0, 0, 0));
        tbl.push_back(mk(1, 1,    3, 0, 0,   1, 0, 0, 0));  // breaks the run
        tbl.push_back(mk(1, 1,   -2, 0, 0,  15, 0, 0, 0));
        tbl.push_back(mk(1, 1,   -2, 0, 0,   1, 1, 0, 1));
        tbl.push_back(mk(1, 1,    0, 0, 0,   4, 1, 0, 0));
        tbl.push_back(mk(1, 1,    0, 0, 0,  10, 1, 0, 0));
        tbl.push_back(mk(1, 0,    3, 0, 0, 100, 1, 0, 0));  // invalid samples ignored
        tbl.push_back(mk(1, 1,    0, 0, 0,   5, 1, 0, 0));
        tbl.push_back(mk(1, 1,    0, 0, 0,   1, 2, 0, 1));

        enable_i = 0; error_valid_i = 0; error_i = '0; force_i = 0; force_gear_i = '0;
        reset_i = 1'b1;
        pulses = 0;
        @(negedge gen_clk_i);
        @(negedge gen_clk_i);
        check("reset_gear",   int'(gear_o), 0);
        check("reset_kp",     int'(kp_o), 3);
        check("reset_ki",     int'(ki_o), 7);
        check("reset_locked", int'(locked_o), 0);
        check("reset_chg",    int'(gear_change_o), 0);
        reset_i = 1'b0;

        // table-driven phases
        total_pulses = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            pulses = 0;
            for (int k = 0; k < tbl[i].n; k++)
                tick(tbl[i].en, tbl[i].v, tbl[i].err, tbl[i].f, tbl[i].fg);
            check($sformatf("row%0d_gear", i),   int'(gear_o),   tbl[i].gear);
            check($sformatf("row%0d_locked", i), int'(locked_o), tbl[i].lock);
            check($sformatf("row%0d_kp", i),     int'(kp_o),     exp_kp(tbl[i].gear));
            check($sformatf("row%0d_ki", i),     int'(ki_o),     exp_ki(tbl[i].gear));
            check($sformatf("row%0d_pulses", i), pulses,         tbl[i].pulses);
            if (i < 9) total_pulses += pulses;
        end
        check("acq_total_pulses", total_pulses, 3);

        // lock, then +16 holds and -128 drops lock into settle
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 3);
        ticks(16, 1, 1, 0);
        check("lk_locked", int'(locked_o), 1);
        check("lk_gear",   int'(gear_o), 3);
        ticks(1, 1, 1, 16);
        check("lk_p16_locked", int'(locked_o), 1);
        pulses = 0;
        ticks(1, 1, 1, -128);
        check("lk_m128_locked", int'(locked_o), 0);
        check("lk_m128_gear",   int'(gear_o), 0);
        check("lk_m128_kp",     int'(kp_o), 3);
        check("lk_m128_ki",     int'(ki_o), 7);
        check("lk_m128_pulses", pulses, 1);
        ticks(19, 1, 1, 0);
        check("lk_settle_hold", int'(gear_o), 0);
        ticks(1, 1, 1, 0);
        check("lk_settle_adv", int'(gear_o), 1);

        // asynchronous reset in the middle of settle at gear 2
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 1);
        ticks(16, 1, 1, 0);
        ticks(1, 1, 1, 0);
        check("rs_pre_gear", int'(gear_o), 2);
        #1 reset_i = 1'b1;
        #1;
        check("rs_gear",   int'(gear_o), 0);
        check("rs_kp",     int'(kp_o), 3);
        check("rs_ki",     int'(ki_o), 7);
        check("rs_locked", int'(locked_o), 0);
        check("rs_chg",    int'(gear_change_o), 0);
        @(posedge gen_clk_i);
        @(negedge gen_clk_i);
        reset_i = 1'b0;
        tick(1, 0, 0, 0, 0);
        ticks(15, 1, 1, 0);
        check("rs_acq_hold", int'(gear_o), 0);
        ticks(1, 1, 1, 0);
        check("rs_acq_adv", int'(gear_o), 1);

        // randomized run against the reference model
        for (int c = 0; c < 4000; c++) begin
            int  sel;
            int  err;
            bit  en;
            bit  f;
            sel = int'($urandom_range(0, 99));
            if (sel < 95)      err = int'($urandom_range(0, 4)) - 2;
            else if (sel < 98) err = int'($urandom_range(0, 40)) - 20;
            else               err = int'($urandom_range(0, 255)) - 128;
            en = ($urandom_range(0, 499) != 0);
            f  = ($urandom_range(0, 299) == 0);
            tick(en, ($urandom_range(0, 9) < 8), err, f, int'($urandom_range(0, 3)));
            check("rnd_gear",   int'(gear_o),        m_gear);
            check("rnd_locked", int'(locked_o),      m_locked);
            check("rnd_chg",    int'(gear_change_o), m_chg);
            check("rnd_kp",     int'(kp_o),          exp_kp(m_gear));
            check("rnd_ki",     int'(ki_o),          exp_ki(m_gear));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
